// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: queues scan-code bytes and replays them as PS/2 keyboard
// frames (start, D0..D7 LSB first, odd parity, stop) toward a host-side
// keyboard decoder. The block drives both PS/2 lines itself.
//
// Ports
//   clk_sys      system clock, rising edge
//   res_n        asynchronous active-low reset
//   data_in[7:0] byte to queue, sampled when wr=1
//   wr           single-cycle write strobe
//   full         FIFO holds FIFO_DEPTH bytes
//   overflow     one-cycle pulse when a write hits a full FIFO
//   busy         FSM active or bytes still queued (registered, one cycle lag)
//   ps2_kbd_clk  PS/2 clock out
//   ps2_kbd_data PS/2 data out
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 1200,
  parameter int GAP        = 2400,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_sys,
  input  logic       res_n,
  input  logic [7:0] data_in,
  input  logic       wr,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       ps2_kbd_clk,
  output logic       ps2_kbd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = FIFO_DEPTH;
  localparam logic [15:0]   DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0]   GAP_M1  = 16'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic [3:0]    idx;
  logic [10:0]   sh;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nxt;
  logic [7:0]    head;
  logic          push, pop;

  // Writes are gated by the registered full flag, so a pop in the same
  // cycle cannot rescue a write that arrives while full.
  assign push = wr & ~full;
  assign pop  = (state == S_IDLE) && (count != '0);
  assign head = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push) count_nxt = count_nxt + CNT_ONE;
    if (pop)  count_nxt = count_nxt - CNT_ONE;
  end

  // Storage needs no reset: emptiness is tracked by count alone.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_nxt;
      full     <= (count_nxt == CNT_MAX);
      overflow <= wr & full;
      busy     <= (state != S_IDLE) || (count != '0);
    end
  end

  // Line outputs are assigned on the same edge as the state change, so the
  // data line moves only on the edge where the clock line rises (or while
  // it is already high), never during a low phase.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '1;
      ps2_kbd_clk  <= 1'b1;
      ps2_kbd_data <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          ps2_kbd_clk  <= 1'b1;
          ps2_kbd_data <= 1'b1;
          if (count != '0) begin
            // frame laid out LSB first: start, data, odd parity, stop
            sh           <= {1'b1, ~^head, head, 1'b0};
            ps2_kbd_data <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
            state        <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (cnt == DIV_M1) begin
            cnt         <= '0;
            ps2_kbd_clk <= 1'b0;
            state       <= S_LOW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_LOW: begin
          if (cnt == DIV_M1) begin
            cnt         <= '0;
            ps2_kbd_clk <= 1'b1;
            if (idx < 4'd10) begin
              idx          <= idx + 4'd1;
              sh           <= {1'b1, sh[10:1]};
              ps2_kbd_data <= sh[1];
              state        <= S_HIGH;
            end else begin
              ps2_kbd_data <= 1'b1;
              state        <= S_GAP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          ps2_kbd_clk  <= 1'b1;
          ps2_kbd_data <= 1'b1;
          if (cnt == GAP_M1) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
module tb_ps2_kbd_tx;
  localparam int C     = 4;
  localparam int G     = 8;
  localparam int D     = 4;
  localparam int FRAME = 22 * C;

  logic       clk_sys = 1'b0;
  logic       res_n   = 1'b1;
  logic       wr      = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full, overflow, busy, ps2_kbd_clk, ps2_kbd_data;

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_tx #(.CLK_DIV(C), .GAP(G), .FIFO_DEPTH(D)) dut (
    .clk_sys(clk_sys), .res_n(res_n), .data_in(data_in), .wr(wr),
    .full(full), .overflow(overflow), .busy(busy),
    .ps2_kbd_clk(ps2_kbd_clk), .ps2_kbd_data(ps2_kbd_data)
  );

  int total = 0;
  int pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // edge counter: time base shared by the bus monitor and the model
  int ecnt = 0;
  always @(posedge clk_sys) ecnt <= ecnt + 1;

  // ---------------- bus monitor / frame decoder ----------------
  logic [10:0] fr;
  int          nb = 0;
  bit          infr = 0;
  logic        pclk = 1'b1, pdat = 1'b1;
  int          lowlen = 0, viol = 0, s0 = 0, sf = 0, data_low = 0;
  logic [10:0] got_fr[$];
  int          got_s0[$], got_sf[$], got_s1[$];

  always @(negedge clk_sys) begin
    if (!res_n) begin
      nb = 0; infr = 0; pclk = 1'b1; pdat = 1'b1; lowlen = 0;
    end else begin
      if (!ps2_kbd_data) data_low++;
      if (!pclk && !ps2_kbd_clk && ps2_kbd_data !== pdat) viol++;
      if (!infr && ps2_kbd_clk && pdat && !ps2_kbd_data) begin
        infr = 1; nb = 0; s0 = ecnt;
      end
      if (pclk && !ps2_kbd_clk) begin
        if (nb == 0) sf = ecnt;
        fr = {ps2_kbd_data, fr[10:1]};
        nb++;
        lowlen = 1;
      end else if (!ps2_kbd_clk) begin
        lowlen++;
      end
      if (!pclk && ps2_kbd_clk) begin
        check("low_len", lowlen, C);
        if (nb == 11) begin
          got_fr.push_back(fr); got_s0.push_back(s0);
          got_sf.push_back(sf); got_s1.push_back(ecnt);
          check("start_bit", fr[0], 0);
          check("stop_bit", fr[10], 1);
          check("odd_parity", ^fr[9:1], 1);
          infr = 0; nb = 0;
        end
      end
      pclk = ps2_kbd_clk;
      pdat = ps2_kbd_data;
    end
  end

  // ---------------- reference model ----------------
  // The transmitter is a server that takes the head byte one edge after it
  // becomes available and is then unavailable for FRAME+G+1 edges.
  logic [7:0] mq[$], exp_tx[$];
  int  next_pop = 0, last_pop = 0, last_e = 0;
  bit  have_pop = 0;
  logic exp_full = 0, exp_ovf = 0, exp_busy = 0;

  task automatic step(input logic w, input logic [7:0] d);
    int  k;
    bit  pre_full, tx_on;
    wr = w; data_in = d;
    @(posedge clk_sys);
    k        = ecnt;
    pre_full = (mq.size() == D);
    tx_on    = have_pop && (k - 1 >= last_pop) && (k - 1 <= last_pop + FRAME + G - 1);
    exp_busy = tx_on || (mq.size() != 0);
    exp_ovf  = w && pre_full;
    if (mq.size() != 0 && k >= next_pop) begin
      exp_tx.push_back(mq.pop_front());
      last_pop = k; have_pop = 1; next_pop = k + FRAME + G + 1;
    end
    if (w && !pre_full) mq.push_back(d);
    exp_full = (mq.size() == D);
    @(negedge clk_sys);
    last_e = ecnt;
    check("full", full, exp_full);
    check("overflow", overflow, exp_ovf);
    check("busy", busy, exp_busy);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(mq.size() == 0 && got_fr.size() == exp_tx.size() &&
             (!have_pop || ecnt > last_pop + FRAME + G + 1)) && n < 3000) begin
      step(1'b0, 8'h00); n++;
    end
    if (n >= 3000) check("idle_timeout", 0, 1);
    repeat (2) step(1'b0, 8'h00);
  endtask

  task automatic compare_tx();
    int m;
    logic [10:0] f;
    check("tx_count", got_fr.size(), exp_tx.size());
    m = (got_fr.size() < exp_tx.size()) ? got_fr.size() : exp_tx.size();
    for (int i = 0; i < m; i++) begin
      f = got_fr[i];
      check("tx_byte", f[8:1], exp_tx[i]);
    end
    got_fr.delete(); got_s0.delete(); got_sf.delete(); got_s1.delete();
    exp_tx.delete();
  endtask

  task automatic model_reset();
    mq.delete(); exp_tx.delete();
    got_fr.delete(); got_s0.delete(); got_sf.delete(); got_s1.delete();
    have_pop = 0; next_pop = 0;
  endtask

  typedef struct { logic [7:0] d; logic [10:0] f; } vec_t;
  vec_t tv[7];

  initial begin
    int e, n, ovf_cnt, acc;
    logic [10:0] f;
    // expected frames {stop, parity, data, start}, worked out by hand
    tv[0] = '{8'h1C, 11'h438};
    tv[1] = '{8'h00, 11'h600};
    tv[2] = '{8'hFF, 11'h7FE};
    tv[3] = '{8'h01, 11'h402};
    tv[4] = '{8'hA5, 11'h74A};
    tv[5] = '{8'h80, 11'h500};
    tv[6] = '{8'h7E, 11'h6FC};

    #1 res_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_clk", ps2_kbd_clk, 1);
    check("rst_data", ps2_kbd_data, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    #2 res_n = 1'b1;

    // single bytes from idle: frame content and timing
    foreach (tv[i]) begin
      step(1'b1, tv[i].d);
      e = last_e;
      wait_idle();
      if (got_fr.size() == 0) check("frame_seen", 0, 1);
      else begin
        f = got_fr[got_fr.size()-1];
        check("frame_bits", f, tv[i].f);
        // start bit visible after edge T+1, first clock fall after T+1+C
        check("start_lat", got_s0[got_s0.size()-1] - e, 1);
        check("fall_lat", got_sf[got_sf.size()-1] - e, 1 + C);
        check("frame_len", got_s1[got_s1.size()-1] - got_s0[got_s0.size()-1], FRAME);
      end
    end
    compare_tx();

    // back-to-back: idle-high spacing between frames
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    wait_idle();
    if (got_fr.size() == 2) check("gap_len", got_s0[1] - got_s1[0], G + 1);
    else check("b2b_frames", got_fr.size(), 2);
    compare_tx();

    // six consecutive writes: fill, overflow, in-order delivery
    ovf_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h10 + 8'(i));
      if (overflow) ovf_cnt++;
    end
    check("ovf_seen", int'(ovf_cnt > 0), 1);
    wait_idle();
    compare_tx();

    // stream of 10 bytes through the FIFO: pointers wrap
    acc = 0; n = 0;
    while (acc < 10 && n < 5000) begin
      if (mq.size() < D) begin step(1'b1, 8'hE0 + 8'(acc)); acc++; end
      else step(1'b0, 8'h00);
      n++;
    end
    check("stream_accepts", acc, 10);
    wait_idle();
    compare_tx();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) == 0) step(1'b1, 8'($urandom_range(255)));
      else step(1'b0, 8'($urandom_range(255)));
    end
    wait_idle();
    compare_tx();
    check("no_data_change_low", viol, 0);

    // reset in the middle of a frame
    step(1'b1, 8'hC3);
    n = 0;
    while (!(nb >= 6 && !ps2_kbd_clk) && n < 500) begin step(1'b0, 8'h00); n++; end
    check("midframe_reached", int'(n < 500), 1);
    #2 res_n = 1'b0;
    #1;
    check("arst_clk", ps2_kbd_clk, 1);
    check("arst_data", ps2_kbd_data, 1);
    check("arst_full", full, 0);
    check("arst_ovf", overflow, 0);
    check("arst_busy", busy, 0);
    @(negedge clk_sys);
    #2 res_n = 1'b1;
    model_reset();
    data_low = 0;
    repeat (150) step(1'b0, 8'h00);
    check("post_rst_frames", got_fr.size(), 0);
    check("post_rst_data_low", data_low, 0);

    // write on the very first edge after reset release
    @(negedge clk_sys);
    #2 res_n = 1'b0;
    @(negedge clk_sys);
    #2 res_n = 1'b1;
    model_reset();
    step(1'b1, 8'h5A);
    e = last_e;
    wait_idle();
    if (got_fr.size() == 1) check("first_edge_start", got_s0[0] - e, 1);
    compare_tx();
    check("no_data_change_low_end", viol, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
